cnt_seq_ctrl: RTL

Sequencer for the 8-bit programmable counter (`prog_counter8`) behind the TinyTapeout top. Holds a small register file (start value, end value, prescale), drives the counter's `en`/`load`/`load_val`/`oe`, and runs the counter from START to END at a prescaled rate. It inserts a one-cycle bus turnaround on the shared bidirectional `uio` pads before each load, then reports completion.

---
 rtl/cnt_seq_pkg.sv | 25 ++
 rtl/cnt_seq_prescaler.sv | 28 ++
 rtl/cnt_seq_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared types and constants for the counter sequencer.
package cnt_seq_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] CFG_START    = 2'd0;
  localparam logic [1:0] CFG_END      = 2'd1;
  localparam logic [1:0] CFG_PRESCALE = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TURN = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } cnt_seq_state_e;

  // Register file contents.
  typedef struct packed {
    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] end_val;
    logic [CNT_W-1:0] prescale;
  } cnt_seq_cfg_t;

endpackage

// File: rtl/cnt_seq_prescaler.sv
// cnt_seq_prescaler: free-running divider; tick every div+1 cycles after clr drops.
module cnt_seq_prescaler
  import cnt_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == div);

  // Held at zero while cleared so the first enabled cycle starts a fresh period.
  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (clr || tick) pre_cnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequences prog_counter8 from START to END at a prescaled rate,
// with a one-cycle uio bus turnaround before each load.
// Optional macro CNT_SEQ_AUTORELOAD_EN: loop START->END until stop instead of
// returning to IDLE after each run.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_en,
  output logic         cnt_load,
  output logic [W-1:0] cnt_load_val,
  output logic         cnt_oe,
  output logic         busy,
  output logic         done
);

  cnt_seq_state_e state_q, state_d;
  cnt_seq_cfg_t   cfg_q, cfg_d;
  logic           tick;
  logic           at_end;

  assign at_end       = (cnt_q == cfg_q.end_val);
  assign cnt_load_val = cfg_q.start_val;

  // Prescaler restarts its period on every entry to RUN.
  cnt_seq_prescaler u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RUN),
    .div   (cfg_q.prescale),
    .tick  (tick)
  );

  // Config writes land only in IDLE; reserved address is dropped.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we && (state_q == IDLE)) begin
      unique case (cfg_addr)
        CFG_START:    cfg_d.start_val = cfg_data;
        CFG_END:      cfg_d.end_val   = cfg_data;
        CFG_PRESCALE: cfg_d.prescale  = cfg_data;
        default:      cfg_d = cfg_q;
      endcase
    end
  end

  // Register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_q <= '0;
    else        cfg_q <= cfg_d;
  end

  // Next-state logic; stop overrides everything, a same-cycle write suppresses start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start && !cfg_we) state_d = TURN;
        TURN: state_d = LOAD;
        LOAD: state_d = RUN;
        RUN:  if (tick && at_end) state_d = DONE;
`ifdef CNT_SEQ_AUTORELOAD_EN
        DONE: state_d = TURN;
`else
        DONE: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output decode; strobes are masked by stop so the counter holds on abort.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_oe   = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: ;
      TURN: begin
        cnt_oe = 1'b0;
        busy   = 1'b1;
      end
      LOAD: begin
        cnt_oe   = 1'b0;
        cnt_load = !stop;
        busy     = 1'b1;
      end
      RUN: begin
        busy   = 1'b1;
        cnt_en = tick && !at_end && !stop;
      end
      DONE: begin
        done = !stop;
`ifdef CNT_SEQ_AUTORELOAD_EN
        busy = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule
